// File: rtl/cfg_byte_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : cfg_byte_transmitter
// Brief    : Drives the byte-serial reconfiguration bus (tracing, configId,
//            configData). The host loads firmware bytes into an internal FIFO
//            and issues per-target commands. A target's bytes are streamed on
//            consecutive cycles only once all of them are buffered.
// Options  : CFG_TX_STATS_EN adds the bytes_sent / cmds_done counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_byte_transmitter #(
    parameter int         FIFO_DEPTH  = 64,
    parameter int         LEN_WIDTH   = $clog2(FIFO_DEPTH + 1),
    parameter logic [7:0] IDLE_ID     = 8'hFF,
    parameter int         TAIL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_id,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 cmd_last,
    output logic                 tracing,
    output logic [7:0]           configId,
    output logic [7:0]           configData,
    output logic                 busy,
    output logic                 err_len
`ifdef CFG_TX_STATS_EN
    ,
    output logic [15:0]          bytes_sent,
    output logic [7:0]           cmds_done
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int                   c_AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LEN_WIDTH-1:0] c_DEPTH     = LEN_WIDTH'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE   = LEN_WIDTH'(1);
    localparam int                   c_TW        = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
    localparam logic [c_TW-1:0]      c_TAIL_LOAD = c_TW'(TAIL_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_SEND      = 3'd2,
        S_GAP       = 3'd3,
        S_WAIT_CMD  = 3'd4,
        S_TAIL      = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [LEN_WIDTH-1:0] r_count;
    logic                 w_push;
    logic                 w_pop;

    // Latched command and tail timer
    logic [7:0]           r_id;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_last;
    logic [c_TW-1:0]      r_tail_cnt;

    // Command handshake decode
    logic                 w_cmd_fire;
    logic                 w_len_bad;
    logic                 w_cmd_accept;
    logic                 w_cmd_reject;

    // Registered bus outputs
    logic                 r_tracing;
    logic [7:0]           r_config_id;
    logic [7:0]           r_config_data;
    logic                 r_busy;
    logic                 r_err_len;

    // ------------------------------------------------------------------------
    // Handshakes. A full FIFO refuses the byte even if a pop happens in the
    // same cycle, which keeps byte_ready a pure function of the count.
    // ------------------------------------------------------------------------
    assign byte_ready   = (r_count < c_DEPTH);
    assign cmd_ready    = (r_state == S_IDLE) || (r_state == S_WAIT_CMD);
    assign w_push       = byte_valid && byte_ready;
    // SEND is only entered with the whole length buffered, so a pop in SEND
    // can never underflow.
    assign w_pop        = (r_state == S_SEND);

    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_len_bad    = (cmd_len == '0) || (cmd_len > c_DEPTH);
    assign w_cmd_accept = w_cmd_fire && !w_len_bad;
    assign w_cmd_reject = w_cmd_fire && w_len_bad;

    // FIFO write port; storage needs no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_data;
        end
    end

    // FIFO pointers and occupancy; a reset flushes whatever was buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_WAIT_CMD: begin
                if (w_cmd_accept) begin
                    w_state_next = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                // Hold off until the full stream is buffered: a receiver
                // counts every cycle its ID is present, so no bubbles.
                if (r_count >= r_len) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (r_len == c_LEN_ONE) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                w_state_next = r_last ? S_TAIL : S_WAIT_CMD;
            end
            S_TAIL: begin
                if (r_tail_cnt == '0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command latch, remaining-length countdown and tail timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id       <= '0;
            r_len      <= '0;
            r_last     <= 1'b0;
            r_tail_cnt <= '0;
        end else begin
            if (w_cmd_accept) begin
                r_id   <= cmd_id;
                r_len  <= cmd_len;
                r_last <= cmd_last;
            end else if (r_state == S_SEND) begin
                r_len  <= r_len - c_LEN_ONE;
            end
            if (r_state == S_GAP) begin
                r_tail_cnt <= c_TAIL_LOAD;
            end else if ((r_state == S_TAIL) && (r_tail_cnt != '0)) begin
                r_tail_cnt <= r_tail_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bus outputs are registered from the current state, which gives the
    // guaranteed IDLE_ID lead cycle between acceptance and the first byte.
    // ------------------------------------------------------------------------
    // Output register stage; configData keeps its last value outside SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tracing     <= 1'b1;
            r_config_id   <= IDLE_ID;
            r_config_data <= 8'h00;
            r_busy        <= 1'b0;
            r_err_len     <= 1'b0;
        end else begin
            r_err_len <= w_cmd_reject;
            r_busy    <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_tracing   <= 1'b1;
                    r_config_id <= IDLE_ID;
                end
                S_SEND: begin
                    r_tracing     <= 1'b0;
                    r_config_id   <= r_id;
                    r_config_data <= r_mem[r_rd_ptr];
                end
                default: begin
                    r_tracing   <= 1'b0;
                    r_config_id <= IDLE_ID;
                end
            endcase
        end
    end

    assign tracing    = r_tracing;
    assign configId   = r_config_id;
    assign configData = r_config_data;
    assign busy       = r_busy;
    assign err_len    = r_err_len;

`ifdef CFG_TX_STATS_EN
    // ------------------------------------------------------------------------
    // Optional statistics: saturating byte count, wrapping command count.
    // ------------------------------------------------------------------------
    logic [15:0] r_bytes_sent;
    logic [7:0]  r_cmds_done;

    // Count streamed bytes and completed targets; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bytes_sent <= '0;
            r_cmds_done  <= '0;
        end else begin
            if ((r_state == S_SEND) && (r_bytes_sent != 16'hFFFF)) begin
                r_bytes_sent <= r_bytes_sent + 1'b1;
            end
            if (r_state == S_GAP) begin
                r_cmds_done <= r_cmds_done + 1'b1;
            end
        end
    end

    assign bytes_sent = r_bytes_sent;
    assign cmds_done  = r_cmds_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_byte_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_byte_transmitter
// Brief    : Self-checking bench for cfg_byte_transmitter. A byte-queue model
//            of the FIFO plus a per-command timeline (lead cycle, stream,
//            gap, wait/tail) gives the expected bus contents each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_byte_transmitter;

    localparam int         DEPTH = 64;
    localparam int         LW    = $clog2(DEPTH + 1);
    localparam int         TAIL  = 4;
    localparam logic [7:0] IDLE  = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_id;
    logic [LW-1:0] cmd_len;
    logic          cmd_last;
    logic          tracing;
    logic [7:0]    configId;
    logic [7:0]    configData;
    logic          busy;
    logic          err_len;
`ifdef CFG_TX_STATS_EN
    logic [15:0]   bytes_sent;
    logic [7:0]    cmds_done;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] id;
        int         len;
        logic       last;
    } cmd_t;

    typedef struct {
        logic       trc;
        logic [7:0] id;
        logic [7:0] data;
        bit         chk_busy;
        logic       busy;
    } exp_t;

    cmd_t       cmd_q[$];
    logic [7:0] model_q[$];
    logic [7:0] mdl_last;

    cfg_byte_transmitter #(
        .FIFO_DEPTH  (DEPTH),
        .LEN_WIDTH   (LW),
        .IDLE_ID     (IDLE),
        .TAIL_CYCLES (TAIL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_len    (cmd_len),
        .cmd_last   (cmd_last),
        .tracing    (tracing),
        .configId   (configId),
        .configData (configData),
        .busy       (busy),
        .err_len    (err_len)
`ifdef CFG_TX_STATS_EN
        ,
        .bytes_sent (bytes_sent),
        .cmds_done  (cmds_done)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Push one byte into the DUT and the model.
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        vectors++;
        if (byte_ready !== (model_q.size() < DEPTH)) begin
            miscompares++;
            $display("FAIL push_ready: got %b expected %b", byte_ready, model_q.size() < DEPTH);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1 byte_valid = 1'b0;
        model_q.push_back(b);
    endtask

    // Issue the queued commands back to back and compare every cycle of the
    // bus against the timeline built from the command list and byte model.
    task automatic run_cmds(input string name);
        exp_t       exp_q[$];
        exp_t       e;
        logic [7:0] ld;
        int         n;
        int         i;
        bit         acc;
        ld = mdl_last;
        exp_q.push_back('{1'b1, IDLE, ld, 1'b0, 1'b0});
        exp_q.push_back('{1'b1, IDLE, ld, 1'b0, 1'b0});
        foreach (cmd_q[j]) begin
            exp_q.push_back('{1'b0, IDLE, ld, 1'b0, 1'b0});
            for (int k = 0; k < cmd_q[j].len; k++) begin
                ld = model_q.pop_front();
                exp_q.push_back('{1'b0, cmd_q[j].id, ld, 1'b1, 1'b1});
            end
            if (cmd_q[j].last) begin
                repeat (1 + TAIL) exp_q.push_back('{1'b0, IDLE, ld, 1'b0, 1'b0});
                exp_q.push_back('{1'b1, IDLE, ld, 1'b1, 1'b0});
            end else begin
                repeat (2) exp_q.push_back('{1'b0, IDLE, ld, 1'b0, 1'b0});
            end
        end
        mdl_last = ld;
        n = cmd_q.size();
        i = 0;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            e = exp_q[c];
            vectors++;
            if (tracing !== e.trc || configId !== e.id || configData !== e.data) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got trc=%b id=%h data=%h, expected trc=%b id=%h data=%h",
                         name, c, tracing, configId, configData, e.trc, e.id, e.data);
            end
            if (e.chk_busy) begin
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s_busy cyc %0d: got %b expected %b", name, c, busy, e.busy);
                end
            end
            acc = (i < n) && (cmd_ready === 1'b1);
            cmd_valid = acc;
            if (acc) begin
                cmd_id   = cmd_q[i].id;
                cmd_len  = LW'(cmd_q[i].len);
                cmd_last = cmd_q[i].last;
            end
            @(posedge clk);
            if (acc) i++;
        end
        #1 cmd_valid = 1'b0;
        vectors++;
        if (i != n) begin
            miscompares++;
            $display("FAIL %s_accepted: got %0d commands expected %0d", name, i, n);
        end
        cmd_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        byte_valid = 1'b0; byte_data = 8'h00;
        cmd_valid = 1'b0; cmd_id = 8'h00; cmd_len = '0; cmd_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors += 7;
        if (tracing !== 1'b1)     begin miscompares++; $display("FAIL rst_tracing: got %b expected 1", tracing); end
        if (configId !== IDLE)    begin miscompares++; $display("FAIL rst_configId: got %h expected ff", configId); end
        if (configData !== 8'h00) begin miscompares++; $display("FAIL rst_configData: got %h expected 00", configData); end
        if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (err_len !== 1'b0)     begin miscompares++; $display("FAIL rst_err_len: got %b expected 0", err_len); end
        if (byte_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_byte_ready: got %b expected 1", byte_ready); end
        if (cmd_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        model_q.delete();
        mdl_last = 8'h00;
    endtask

    task automatic test_single_target();
        for (int b = 8'h11; b <= 8'h16; b++) push_byte(8'(b));
        cmd_q.push_back('{8'd3, 6, 1'b1});
        run_cmds("single");
    endtask

    task automatic test_late_data();
        logic       o_trc [40];
        logic [7:0] o_id  [40];
        logic [7:0] o_dat [40];
        logic [7:0] exp_b [4];
        int np;
        int c4;
        int first;
        int bad;
        np = 0; c4 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            o_trc[c] = tracing; o_id[c] = configId; o_dat[c] = configData;
            cmd_valid = (c == 0);
            cmd_id = 8'd2; cmd_len = LW'(4); cmd_last = 1'b1;
            byte_valid = ((c % 3) == 0) && (np < 4);
            byte_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            if (byte_valid) begin
                model_q.push_back(byte_data);
                np++;
                if (np == 4) c4 = c;
            end
            #1 byte_valid = 1'b0; cmd_valid = 1'b0;
        end
        first = -1;
        for (int c = 0; c < 40; c++) if (first < 0 && o_id[c] !== IDLE) first = c;
        bad = 0;
        for (int c = 0; c <= c4; c++) if (o_id[c] !== IDLE) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL late_early_id: got %0d non-idle cycles before 4th byte, expected 0", bad); end
        vectors++;
        if (first <= c4 || first > c4 + 6) begin
            miscompares++;
            $display("FAIL late_start: got first byte at cycle %0d, expected in (%0d,%0d]", first, c4, c4 + 6);
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_b[k] = model_q.pop_front();
                vectors++;
                if (o_id[first+k] !== 8'd2 || o_dat[first+k] !== exp_b[k] || o_trc[first+k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL late_byte%0d: got id=%h data=%h expected id=02 data=%h", k, o_id[first+k], o_dat[first+k], exp_b[k]);
                end
            end
            mdl_last = exp_b[3];
            vectors++;
            if (o_id[first+4] !== IDLE) begin miscompares++; $display("FAIL late_gap: got id=%h expected ff", o_id[first+4]); end
            bad = 0;
            for (int c = 2; c < first + 4; c++) if (o_trc[c] !== 1'b0) bad++;
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL late_tracing: got %0d cycles with tracing=1, expected 0", bad); end
        end
        vectors++;
        if (o_trc[39] !== 1'b1) begin miscompares++; $display("FAIL late_end_tracing: got %b expected 1", o_trc[39]); end
    endtask

    task automatic test_two_targets();
        repeat (5) push_byte(8'($urandom_range(0, 255)));
        cmd_q.push_back('{8'd0, 2, 1'b0});
        cmd_q.push_back('{8'd1, 3, 1'b1});
        run_cmds("two_targets");
    endtask

    task automatic test_len_errors();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_id    = 8'd5;
            cmd_len   = (t == 0) ? LW'(0) : LW'(DEPTH + 1);
            cmd_last  = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
            vectors += 4;
            if (err_len !== 1'b1)   begin miscompares++; $display("FAIL err_pulse%0d: got %b expected 1", t, err_len); end
            if (tracing !== 1'b1)   begin miscompares++; $display("FAIL err_tracing%0d: got %b expected 1", t, tracing); end
            if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL err_idle%0d: got cmd_ready %b expected 1", t, cmd_ready); end
            if (busy !== 1'b0)      begin miscompares++; $display("FAIL err_busy%0d: got %b expected 0", t, busy); end
            @(negedge clk);
            vectors += 2;
            if (err_len !== 1'b0)   begin miscompares++; $display("FAIL err_once%0d: got %b expected 0", t, err_len); end
            if (tracing !== 1'b1)   begin miscompares++; $display("FAIL err_stay%0d: got tracing %b expected 1", t, tracing); end
        end
    endtask

    task automatic test_fifo_full();
        for (int k = 0; k < DEPTH; k++) push_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        vectors++;
        if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b expected 0", byte_ready); end
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        @(posedge clk);
        #1 byte_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_after: got %b expected 0", byte_ready); end
        cmd_q.push_back('{8'd9, DEPTH, 1'b1});
        run_cmds("full_drain");
        vectors++;
        if (byte_ready !== 1'b1) begin miscompares++; $display("FAIL drained_ready: got %b expected 1", byte_ready); end
    endtask

    task automatic test_reset_mid_send();
        int         seen;
        bit         hit;
        logic [7:0] eb;
        repeat (5) push_byte(8'($urandom_range(0, 255)));
        seen = 0; hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (configId === 8'd7) begin
                seen++;
                eb = model_q.pop_front();
                vectors++;
                if (configData !== eb) begin miscompares++; $display("FAIL midrst_byte%0d: got %h expected %h", seen, configData, eb); end
            end
            if (seen == 3) begin
                hit = 1'b1;
            end else begin
                cmd_valid = (c == 0);
                cmd_id = 8'd7; cmd_len = LW'(5); cmd_last = 1'b1;
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL midrst_reach: got %0d bytes within budget expected 3", seen);
        end else begin
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            vectors += 5;
            if (tracing !== 1'b1)     begin miscompares++; $display("FAIL midrst_tracing: got %b expected 1", tracing); end
            if (configId !== IDLE)    begin miscompares++; $display("FAIL midrst_configId: got %h expected ff", configId); end
            if (configData !== 8'h00) begin miscompares++; $display("FAIL midrst_configData: got %h expected 00", configData); end
            if (busy !== 1'b0)        begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
            if (byte_ready !== 1'b1)  begin miscompares++; $display("FAIL midrst_byte_ready: got %b expected 1", byte_ready); end
        end
        model_q.delete();
        mdl_last = 8'h00;
        // A flushed FIFO delivers only the bytes pushed from here on.
        push_byte(8'h5A);
        push_byte(8'hC3);
        cmd_q.push_back('{8'd4, 2, 1'b1});
        run_cmds("after_reset");
    endtask

    task automatic test_random();
        int ncmd;
        int total;
        int room;
        int surplus;
        for (int r = 0; r < 6; r++) begin
            ncmd  = $urandom_range(1, 3);
            total = 0;
            for (int j = 0; j < ncmd; j++) begin
                cmd_q.push_back('{8'($urandom_range(0, 254)), int'($urandom_range(1, 12)), (j == ncmd - 1)});
                total += cmd_q[j].len;
            end
            room    = DEPTH - model_q.size() - total;
            surplus = (room > 3) ? int'($urandom_range(0, 3)) : 0;
            repeat (total + surplus) push_byte(8'($urandom_range(0, 255)));
            run_cmds("random");
        end
    endtask

    initial begin
        test_reset();
        test_single_target();
        test_late_data();
        test_two_targets();
        test_len_errors();
        test_fifo_full();
        test_reset_mid_send();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
